// File: rtl/adc_calib_bank_pkg.sv
// Shared constants, commit state encoding and the float32 write-legality rule
// for the ADC gain/offset calibration bank.
package adc_calib_pkg;

    localparam int unsigned NCH        = 10;
    localparam logic [31:0] GAIN_MAIN  = 32'h35A0_0000;
    localparam logic [31:0] GAIN_SUB   = 32'h39A0_00A0;
    localparam logic [31:0] OFFSET_RST = 32'hC120_0000;

    typedef enum logic [1:0] {IDLE, PEND, APPLY} calib_state_e;

    // Rejects Inf/NaN and denormals; zero and normal values are accepted.
    function automatic logic f32_legal(input logic [31:0] data);
        logic [7:0]  exp_f;
        logic [22:0] man_f;
        exp_f = data[30:23];
        man_f = data[22:0];
        return (exp_f != 8'hFF) && !((exp_f == 8'h00) && (man_f != 23'd0));
    endfunction

endpackage

// File: rtl/adc_calib_bank_if.sv
// Register-bank bus: PS-side write/commit/readback controls plus the packed
// gain/offset streams feeding the per-channel multiply-add.
interface adc_calib_bank_if #(
    parameter int unsigned NCH = adc_calib_pkg::NCH
);
    logic              i_wr_en;
    logic [4:0]        i_wr_addr;
    logic [31:0]       i_wr_data;
    logic              i_commit;
    logic              i_calc_busy;
    logic [4:0]        i_rd_addr;
    logic              i_err_clr;
    logic [31:0]       o_rd_data;
    logic [NCH*32-1:0] o_gain_tdata;
    logic [NCH*32-1:0] o_offset_tdata;
    logic [NCH-1:0]    o_gain_tvalid;
    logic [NCH-1:0]    o_offset_tvalid;
    logic              o_pending;
    logic              o_wr_err;
    logic [15:0]       o_commit_cnt;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_commit, i_calc_busy, i_rd_addr, i_err_clr,
        input  o_rd_data, o_gain_tdata, o_offset_tdata, o_gain_tvalid, o_offset_tvalid,
        input  o_pending, o_wr_err, o_commit_cnt
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_commit, i_calc_busy, i_rd_addr, i_err_clr,
        output o_rd_data, o_gain_tdata, o_offset_tdata, o_gain_tvalid, o_offset_tvalid,
        output o_pending, o_wr_err, o_commit_cnt
    );

endinterface

// File: rtl/adc_calib_ctrl.sv
// Commit sequencer: holds a commit until the calculation stage is idle, then
// spends one cycle with tvalid low while the active bank is reloaded.
module adc_calib_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_commit,
    input  logic        i_calc_busy,
    output logic        o_pending,
    output logic        o_apply,
    output logic        o_tvalid,
    output logic [15:0] o_commit_cnt
);
    import adc_calib_pkg::*;

    calib_state_e state_q;
    logic         pending_q;
    logic         apply_q;
    logic         tvalid_q;
    logic [15:0]  commit_cnt_q;

    // State machine with registered outputs; commits outside IDLE are absorbed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            apply_q      <= 1'b0;
            tvalid_q     <= 1'b1;
            commit_cnt_q <= 16'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_commit) begin
                        state_q   <= PEND;
                        pending_q <= 1'b1;
                    end
                end
                PEND: begin
                    if (!i_calc_busy) begin
                        state_q   <= APPLY;
                        pending_q <= 1'b0;
                        apply_q   <= 1'b1;
                        tvalid_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    state_q      <= IDLE;
                    apply_q      <= 1'b0;
                    tvalid_q     <= 1'b1;
                    commit_cnt_q <= commit_cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_pending    = pending_q;
    assign o_apply      = apply_q;
    assign o_tvalid     = tvalid_q;
    assign o_commit_cnt = commit_cnt_q;

endmodule

// File: rtl/adc_calib_bank.sv
// Double-buffered float32 gain/offset bank. Writes land in the shadow bank;
// the active bank driving the datapath is reloaded only by an applied commit.
module adc_calib_bank #(
    parameter int unsigned NCH        = adc_calib_pkg::NCH,
    parameter logic [31:0] GAIN_MAIN  = adc_calib_pkg::GAIN_MAIN,
    parameter logic [31:0] GAIN_SUB   = adc_calib_pkg::GAIN_SUB,
    parameter logic [31:0] OFFSET_RST = adc_calib_pkg::OFFSET_RST
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    adc_calib_bank_if.slave bus
);
    import adc_calib_pkg::*;

    logic [31:0] gain_sh_q  [NCH];
    logic [31:0] off_sh_q   [NCH];
    logic [31:0] gain_act_q [NCH];
    logic [31:0] off_act_q  [NCH];
    logic        wr_err_q;
    logic [31:0] rd_data_q;

    logic [31:0] wr_ch;
    logic [31:0] rd_ch;
    logic        wr_ok;
    logic        wr_rej;
    logic        apply;
    logic        tvalid;
    logic [31:0] rd_mux;

    // Channels 0..1 are the main I/V paths, the rest are sub-channels.
    function automatic logic [31:0] gain_rst(input int unsigned n);
        return (n < 2) ? GAIN_MAIN : GAIN_SUB;
    endfunction

    assign wr_ch  = 32'(bus.i_wr_addr[4:1]);
    assign rd_ch  = 32'(bus.i_rd_addr[4:1]);
    assign wr_ok  = f32_legal(bus.i_wr_data) && (wr_ch < NCH);
    assign wr_rej = bus.i_wr_en && !wr_ok;

    adc_calib_ctrl u_ctrl (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_commit     (bus.i_commit),
        .i_calc_busy  (bus.i_calc_busy),
        .o_pending    (bus.o_pending),
        .o_apply      (apply),
        .o_tvalid     (tvalid),
        .o_commit_cnt (bus.o_commit_cnt)
    );

    // Shadow bank: accepted writes only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                gain_sh_q[n] <= gain_rst(n);
                off_sh_q[n]  <= OFFSET_RST;
            end
        end else if (bus.i_wr_en && wr_ok) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                if (wr_ch == n) begin
                    if (bus.i_wr_addr[0]) off_sh_q[n]  <= bus.i_wr_data;
                    else                  gain_sh_q[n] <= bus.i_wr_data;
                end
            end
        end
    end

    // Active bank: copies the pre-edge shadow, so a same-cycle write misses it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                gain_act_q[n] <= gain_rst(n);
                off_act_q[n]  <= OFFSET_RST;
            end
        end else if (apply) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                gain_act_q[n] <= gain_sh_q[n];
                off_act_q[n]  <= off_sh_q[n];
            end
        end
    end

    // Sticky reject flag; a reject wins over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)           wr_err_q <= 1'b0;
        else if (wr_rej)        wr_err_q <= 1'b1;
        else if (bus.i_err_clr) wr_err_q <= 1'b0;
    end

    // Readback mux over the active bank; out-of-range channels read 0.
    always_comb begin
        rd_mux = 32'd0;
        for (int unsigned n = 0; n < NCH; n++) begin
            if (rd_ch == n) rd_mux = bus.i_rd_addr[0] ? off_act_q[n] : gain_act_q[n];
        end
    end

    // Registered readback.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rd_data_q <= 32'd0;
        else          rd_data_q <= rd_mux;
    end

    // Pack the active bank onto the per-channel stream buses.
    always_comb begin
        bus.o_gain_tdata   = '0;
        bus.o_offset_tdata = '0;
        for (int unsigned n = 0; n < NCH; n++) begin
            bus.o_gain_tdata[32*n +: 32]   = gain_act_q[n];
            bus.o_offset_tdata[32*n +: 32] = off_act_q[n];
        end
    end

    assign bus.o_gain_tvalid   = {NCH{tvalid}};
    assign bus.o_offset_tvalid = {NCH{tvalid}};
    assign bus.o_wr_err        = wr_err_q;
    assign bus.o_rd_data       = rd_data_q;

endmodule

// File: tb/tb_adc_calib_bank.sv
// Directed bench for adc_calib_bank: a cycle model of the bank's documented
// behaviour is compared against the DUT every cycle, plus literal spot checks.
module tb_adc_calib_bank;
    import adc_calib_pkg::*;

    localparam int N = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_calib_bank_if #(.NCH(N)) bus ();

    adc_calib_bank #(.NCH(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Model state
    logic [31:0] m_sg [N];
    logic [31:0] m_so [N];
    logic [31:0] m_ag [N];
    logic [31:0] m_ao [N];
    logic        m_pend;
    logic        m_apply;
    logic        m_err;
    logic [15:0] m_cnt;
    logic [31:0] m_rd;
    int          m_ch;
    int          m_rch;
    logic        m_ok;
    logic [7:0]  m_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending flag, one apply cycle, then copy + count.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int n = 0; n < N; n++) begin
                m_sg[n] = (n < 2) ? 32'h35A0_0000 : 32'h39A0_00A0;
                m_so[n] = 32'hC120_0000;
                m_ag[n] = m_sg[n];
                m_ao[n] = m_so[n];
            end
            m_pend = 1'b0; m_apply = 1'b0; m_err = 1'b0; m_cnt = 16'd0; m_rd = 32'd0;
        end else begin
            m_rch = int'(bus.i_rd_addr[4:1]);
            m_rd  = 32'd0;
            if (m_rch < N) m_rd = bus.i_rd_addr[0] ? m_ao[m_rch] : m_ag[m_rch];
            if (m_apply) begin
                for (int n = 0; n < N; n++) begin
                    m_ag[n] = m_sg[n];
                    m_ao[n] = m_so[n];
                end
                m_cnt   = m_cnt + 16'd1;
                m_apply = 1'b0;
            end else if (m_pend) begin
                if (!bus.i_calc_busy) begin
                    m_pend  = 1'b0;
                    m_apply = 1'b1;
                end
            end else if (bus.i_commit) begin
                m_pend = 1'b1;
            end
            m_ch  = int'(bus.i_wr_addr[4:1]);
            m_exp = bus.i_wr_data[30:23];
            m_ok  = (m_exp != 8'hFF) && !(m_exp == 8'h00 && bus.i_wr_data[22:0] != 23'd0)
                    && (m_ch < N);
            if (bus.i_wr_en && m_ok) begin
                if (bus.i_wr_addr[0]) m_so[m_ch] = bus.i_wr_data;
                else                  m_sg[m_ch] = bus.i_wr_data;
            end
            if (bus.i_wr_en && !m_ok) m_err = 1'b1;
            else if (bus.i_err_clr)   m_err = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int n = 0; n < N; n++) begin
                chk($sformatf("gain_tdata[%0d]", n), bus.o_gain_tdata[32*n +: 32], m_ag[n]);
                chk($sformatf("offset_tdata[%0d]", n), bus.o_offset_tdata[32*n +: 32], m_ao[n]);
            end
            chk("gain_tvalid", 32'(bus.o_gain_tvalid), m_apply ? 32'h0 : 32'h3FF);
            chk("offset_tvalid", 32'(bus.o_offset_tvalid), m_apply ? 32'h0 : 32'h3FF);
            chk("pending", 32'(bus.o_pending), 32'(m_pend));
            chk("wr_err", 32'(bus.o_wr_err), 32'(m_err));
            chk("commit_cnt", 32'(bus.o_commit_cnt), 32'(m_cnt));
            chk("rd_data", bus.o_rd_data, m_rd);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
        tick();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic commit_pulse();
        bus.i_commit = 1'b1;
        tick();
        bus.i_commit = 1'b0;
    endtask

    task automatic err_clr_pulse();
        bus.i_err_clr = 1'b1;
        tick();
        bus.i_err_clr = 1'b0;
    endtask

    logic [31:0] rej_data [4] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0001, 32'h3F80_0000};
    logic [4:0]  rej_addr [4] = '{5'd0, 5'd2, 5'd4, 5'd24};

    initial begin
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_commit = 1'b0;
        bus.i_calc_busy = 1'b0; bus.i_rd_addr = '0; bus.i_err_clr = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        started = 1'b1;

        // Reset readback of all 20 indices plus one out-of-range index
        for (int a = 0; a < 20; a++) begin
            bus.i_rd_addr = 5'(a);
            tick();
            if (a == 0) chk("rd ch0 gain", bus.o_rd_data, 32'h35A0_0000);
            if (a == 6) chk("rd ch3 gain", bus.o_rd_data, 32'h39A0_00A0);
            if (a[0])   chk("rd offset", bus.o_rd_data, 32'hC120_0000);
        end
        chk("rst tvalid", 32'(bus.o_gain_tvalid), 32'h3FF);
        chk("rst commit_cnt", 32'(bus.o_commit_cnt), 32'h0);
        bus.i_rd_addr = 5'd25;
        tick();
        chk("rd ch12", bus.o_rd_data, 32'h0);

        // Shadow write is invisible until commit; commit applies 3 cycles later
        wr(5'd4, 32'h3F80_0000);
        tick(3);
        chk("ch2 gain pre-commit", bus.o_gain_tdata[95:64], 32'h39A0_00A0);
        commit_pulse();
        chk("cycle1 pending", 32'(bus.o_pending), 32'h1);
        chk("cycle1 tvalid", 32'(bus.o_gain_tvalid), 32'h3FF);
        tick();
        chk("cycle2 tvalid", 32'(bus.o_gain_tvalid), 32'h0);
        chk("cycle2 ch2 gain", bus.o_gain_tdata[95:64], 32'h39A0_00A0);
        tick();
        chk("cycle3 tvalid", 32'(bus.o_gain_tvalid), 32'h3FF);
        chk("cycle3 ch2 gain", bus.o_gain_tdata[95:64], 32'h3F80_0000);
        chk("cycle3 commit_cnt", 32'(bus.o_commit_cnt), 32'h1);
        bus.i_rd_addr = 5'd4;
        tick();
        chk("rd ch2 gain", bus.o_rd_data, 32'h3F80_0000);

        // Commit held off by busy for 50 cycles, second commit absorbed
        wr(5'd3, 32'h4000_0000);
        bus.i_calc_busy = 1'b1;
        commit_pulse();
        for (int i = 0; i < 50; i++) begin
            bus.i_commit = (i == 10);
            tick();
            chk("busy pending", 32'(bus.o_pending), 32'h1);
            chk("busy ch1 offset", bus.o_offset_tdata[63:32], 32'hC120_0000);
        end
        bus.i_commit = 1'b0;
        bus.i_calc_busy = 1'b0;
        tick();
        chk("apply after busy tvalid", 32'(bus.o_gain_tvalid), 32'h0);
        tick();
        chk("after busy ch1 offset", bus.o_offset_tdata[63:32], 32'h4000_0000);
        chk("after busy commit_cnt", 32'(bus.o_commit_cnt), 32'h2);
        tick(5);
        chk("absorbed commit_cnt", 32'(bus.o_commit_cnt), 32'h2);

        // Write in the commit cycle is included
        bus.i_commit = 1'b1;
        wr(5'd8, 32'h4040_0000);
        bus.i_commit = 1'b0;
        tick(2);
        chk("same-cycle ch4 gain", bus.o_gain_tdata[159:128], 32'h4040_0000);
        chk("same-cycle commit_cnt", 32'(bus.o_commit_cnt), 32'h3);

        // Write during APPLY misses the copy
        commit_pulse();
        tick();
        wr(5'd10, 32'h4080_0000);
        chk("apply-write ch5 gain", bus.o_gain_tdata[191:160], 32'h39A0_00A0);
        chk("apply-write commit_cnt", 32'(bus.o_commit_cnt), 32'h4);
        commit_pulse();
        tick(2);
        chk("late ch5 gain", bus.o_gain_tdata[191:160], 32'h4080_0000);

        // Rejected writes
        for (int i = 0; i < 4; i++) begin
            wr(rej_addr[i], rej_data[i]);
            chk("reject sets wr_err", 32'(bus.o_wr_err), 32'h1);
            err_clr_pulse();
            chk("err_clr", 32'(bus.o_wr_err), 32'h0);
        end
        bus.i_err_clr = 1'b1;
        wr(5'd2, 32'h7F80_0000);
        bus.i_err_clr = 1'b0;
        chk("clr+reject wr_err", 32'(bus.o_wr_err), 32'h1);
        err_clr_pulse();
        wr(5'd19, 32'h0000_0000);
        chk("zero legal wr_err", 32'(bus.o_wr_err), 32'h0);
        commit_pulse();
        tick(2);
        chk("rej ch0 gain", bus.o_gain_tdata[31:0], 32'h35A0_0000);
        chk("rej ch1 gain", bus.o_gain_tdata[63:32], 32'h35A0_0000);
        chk("rej ch2 gain", bus.o_gain_tdata[95:64], 32'h3F80_0000);
        chk("ch9 offset zero", bus.o_offset_tdata[319:288], 32'h0);

        // Reset in the middle of PEND discards the commit
        wr(5'd12, 32'h4100_0000);
        bus.i_calc_busy = 1'b1;
        commit_pulse();
        tick(3);
        chk("pre-reset pending", 32'(bus.o_pending), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.i_calc_busy = 1'b0;
        bus.i_rd_addr = 5'd12;
        tick(5);
        chk("post-reset pending", 32'(bus.o_pending), 32'h0);
        chk("post-reset commit_cnt", 32'(bus.o_commit_cnt), 32'h0);
        chk("post-reset ch2 gain", bus.o_gain_tdata[95:64], 32'h39A0_00A0);
        chk("post-reset ch6 gain", bus.o_gain_tdata[223:192], 32'h39A0_00A0);
        chk("post-reset rd ch6", bus.o_rd_data, 32'h39A0_00A0);

        // Counter wrap: seed both DUT and model at FFFF rather than issue 65535 commits
        @(posedge clk);
        #2;
        dut.u_ctrl.commit_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        chk("seeded commit_cnt", 32'(bus.o_commit_cnt), 32'hFFFF);
        commit_pulse();
        tick(2);
        chk("wrapped commit_cnt", 32'(bus.o_commit_cnt), 32'h0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
